// File: rtl/pe_seq_pkg.sv
// Shared constants and FSM state encoding for the PE memory sequencer.
// The CLEAR state exists only when PE_SEQ_DRAIN_CLEAR_EN is defined.
package pe_seq_pkg;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int LEN_W  = 7;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILL       = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_CAPTURE = 3'd3,
    OUT_HOLD   = 3'd4,
`ifdef PE_SEQ_DRAIN_CLEAR_EN
    CLEAR      = 3'd5,
`endif
    DONE       = 3'd6
  } seq_state_t;

endpackage

// File: rtl/pe_seq_row_counter.sv
// Row counter for the PE memory sequencer: synchronous clear, increment,
// and a terminal flag when the count reaches the last row index.
// The counter never steps past the last index, so it cannot wrap.
module pe_seq_row_counter
  import pe_seq_pkg::*;
(
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  assign last = (count == last_idx);

  // count register: clear has priority, increment stops at the last row
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pe_mem_sequencer.sv
// PE memory sequencer: fills len rows of the PE memory from the input
// stream, then reads them back one at a time onto the output stream.
// Optional feature macro: PE_SEQ_DRAIN_CLEAR_EN adds a one-cycle memory
// clear (r_mem_ready low) after the last drained word.
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | waiting for w_start; memory enabled, nothing in flight
// FILL       | accept input words, store one row per handshake
// RD_ISSUE   | present read address of the current row
// RD_CAPTURE | register memory read data into r_out_data
// OUT_HOLD   | r_out_valid high until w_out_ready
// CLEAR      | (PE_SEQ_DRAIN_CLEAR_EN) r_mem_ready low for one cycle
// DONE       | r_done pulse, then back to IDLE
module pe_mem_sequencer
  import pe_seq_pkg::*;
#(
  parameter int num_bits = 8,
  parameter int DEPTH    = pe_seq_pkg::DEPTH
) (
  input  logic                w_clk,
  input  logic                w_rst_n,
  input  logic                w_start,
  input  logic [LEN_W-1:0]    w_len,
  input  logic                w_in_valid,
  input  logic [num_bits-1:0] w_in_data,
  output logic                r_in_ready,
  output logic                r_out_valid,
  output logic [num_bits-1:0] r_out_data,
  output logic                r_out_last,
  input  logic                w_out_ready,
  output logic                r_mem_ready,
  output logic                r_mem_rw,
  output logic [ADDR_W-1:0]   r_mem_address,
  output logic [num_bits-1:0] r_mem_data_in,
  input  logic [num_bits-1:0] w_mem_data_out,
  output logic                r_busy,
  output logic                r_done
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

  seq_state_t          state, nxt_state;
  logic [LEN_W-1:0]    len_sat;
  logic [ADDR_W-1:0]   last_idx;
  logic [ADDR_W-1:0]   row;
  logic                row_last;
  logic                cnt_clr;
  logic                cnt_inc;
  logic                len_ld;
  logic                mem_ready_c;
  logic                mem_rw_c;
  logic [num_bits-1:0] mem_data_c;

  assign len_sat = (w_len > MAX_LEN) ? MAX_LEN : w_len;

  pe_seq_row_counter u_row_counter (
    .w_clk    (w_clk),
    .w_rst_n  (w_rst_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .last_idx (last_idx),
    .count    (row),
    .last     (row_last)
  );

  // state register
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  // latch the saturated length as a last-row index when a run starts
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      last_idx <= '0;
    end else if (len_ld) begin
      last_idx <= ADDR_W'(len_sat - 1'b1);
    end
  end

  // read data is captured one cycle after the address was issued
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_out_data <= '0;
    end else if (state == RD_CAPTURE) begin
      r_out_data <= w_mem_data_out;
    end
  end

  // next-state and memory-side control
  always_comb begin
    nxt_state   = state;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    len_ld      = 1'b0;
    mem_ready_c = 1'b1;
    mem_rw_c    = 1'b0;
    mem_data_c  = '0;
    case (state)
      IDLE: begin
        if (w_start) begin
          len_ld    = 1'b1;
          cnt_clr   = 1'b1;
          nxt_state = (len_sat == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (w_in_valid) begin
          mem_rw_c   = 1'b1;
          mem_data_c = w_in_data;
          if (row_last) begin
            cnt_clr   = 1'b1;
            nxt_state = RD_ISSUE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        nxt_state = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        nxt_state = OUT_HOLD;
      end
      OUT_HOLD: begin
        if (w_out_ready) begin
          if (row_last) begin
`ifdef PE_SEQ_DRAIN_CLEAR_EN
            nxt_state = CLEAR;
`else
            nxt_state = DONE;
`endif
          end else begin
            cnt_inc   = 1'b1;
            nxt_state = RD_ISSUE;
          end
        end
      end
`ifdef PE_SEQ_DRAIN_CLEAR_EN
      CLEAR: begin
        mem_ready_c = 1'b0;
        nxt_state   = DONE;
      end
`endif
      DONE: begin
        nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // memory outputs are forced low while reset is held so the memory clears
  assign r_mem_ready   = w_rst_n & mem_ready_c;
  assign r_mem_rw      = w_rst_n & mem_rw_c;
  assign r_mem_address = w_rst_n ? row : '0;
  assign r_mem_data_in = w_rst_n ? mem_data_c : '0;

  assign r_in_ready  = (state == FILL);
  assign r_out_valid = (state == OUT_HOLD);
  assign r_out_last  = (state == OUT_HOLD) && row_last;
  assign r_done      = (state == DONE);
  assign r_busy      = (state != IDLE);

endmodule

// File: tb/tb_pe_mem_sequencer.sv
// Randomised self-checking bench for pe_mem_sequencer with a behavioural
// memory and a queue-based reference of the expected stores and outputs.
module tb_pe_mem_sequencer;

`ifdef PE_SEQ_DRAIN_CLEAR_EN
  localparam int CLR_CYC = 1;
`else
  localparam int CLR_CYC = 0;
`endif

  logic       w_clk = 1'b0;
  logic       w_rst_n = 1'b1;
  logic       w_start = 1'b0;
  logic [6:0] w_len = '0;
  logic       w_in_valid = 1'b0;
  logic [7:0] w_in_data = '0;
  logic       r_in_ready;
  logic       r_out_valid;
  logic [7:0] r_out_data;
  logic       r_out_last;
  logic       w_out_ready = 1'b0;
  logic       r_mem_ready;
  logic       r_mem_rw;
  logic [5:0] r_mem_address;
  logic [7:0] r_mem_data_in;
  logic [7:0] w_mem_data_out = '0;
  logic       r_busy;
  logic       r_done;

  int errors = 0;
  int checks = 0;

  pe_mem_sequencer #(.num_bits(8), .DEPTH(64)) dut (
    .w_clk          (w_clk),
    .w_rst_n        (w_rst_n),
    .w_start        (w_start),
    .w_len          (w_len),
    .w_in_valid     (w_in_valid),
    .w_in_data      (w_in_data),
    .r_in_ready     (r_in_ready),
    .r_out_valid    (r_out_valid),
    .r_out_data     (r_out_data),
    .r_out_last     (r_out_last),
    .w_out_ready    (w_out_ready),
    .r_mem_ready    (r_mem_ready),
    .r_mem_rw       (r_mem_rw),
    .r_mem_address  (r_mem_address),
    .r_mem_data_in  (r_mem_data_in),
    .w_mem_data_out (w_mem_data_out),
    .r_busy         (r_busy),
    .r_done         (r_done)
  );

  always #5 w_clk = ~w_clk;

  // behavioural PE memory: one-cycle read latency, cleared while ready is low
  logic [7:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  always @(posedge w_clk) begin
    if (!r_mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (r_mem_rw) begin
      mem[r_mem_address] <= r_mem_data_in;
    end
    w_mem_data_out <= mem[r_mem_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: the first min(len,64) accepted words are stored at rows
  // 0,1,2.. and come back out in the same order, last flag on the final one
  logic [7:0] exp_q[$];
  int   store_idx, out_idx, n_done, last_cnt, mem_lo_cnt;
  int   lo_cyc, done_cyc, last_hs_cyc, cyc;
  bit   busy_m, prev_hold, tput_chk;
  logic [7:0] prev_data, first_out, last_out;

  initial begin
    store_idx = 0; out_idx = 0; n_done = 0; last_cnt = 0; mem_lo_cnt = 0;
    lo_cyc = 0; done_cyc = 0; last_hs_cyc = -1; cyc = 0;
    busy_m = 0; prev_hold = 0; tput_chk = 0;
    prev_data = '0; first_out = '0; last_out = '0;
  end

  // compare process: every cycle out of reset, sampled mid-cycle
  always @(negedge w_clk) begin
    cyc++;
    if (!w_rst_n) begin
      busy_m    = 0;
      prev_hold = 0;
    end else begin
      chk("busy", r_busy, busy_m);
      chk("store_only_on_handshake", r_mem_rw, w_in_valid && r_in_ready);
      chk("last_without_valid", r_out_last && !r_out_valid, 0);
      if (!r_mem_ready) begin
        mem_lo_cnt++;
        lo_cyc = cyc;
      end
      if (prev_hold) begin
        chk("hold_valid", r_out_valid, 1);
        chk("hold_data", r_out_data, prev_data);
      end
      if (r_mem_rw) begin
        if (store_idx < exp_q.size()) begin
          chk("store_addr", r_mem_address, store_idx);
          chk("store_data", r_mem_data_in, exp_q[store_idx]);
        end else begin
          chk("extra_store", store_idx, exp_q.size());
        end
        store_idx++;
      end
      if (r_out_valid && w_out_ready) begin
        chk("fill_before_drain", store_idx, exp_q.size());
        if (out_idx < exp_q.size()) begin
          chk("out_data", r_out_data, exp_q[out_idx]);
          chk("out_last", r_out_last, out_idx == exp_q.size() - 1);
        end else begin
          chk("extra_out", out_idx, exp_q.size());
        end
        if (out_idx == 0) first_out = r_out_data;
        last_out = r_out_data;
        if (r_out_last) last_cnt++;
        if (tput_chk && last_hs_cyc >= 0) chk("drain_rate", cyc - last_hs_cyc, 3);
        last_hs_cyc = cyc;
        out_idx++;
      end
      if (r_done) begin
        chk("done_stores", store_idx, exp_q.size());
        chk("done_outs", out_idx, exp_q.size());
        n_done++;
        done_cyc = cyc;
      end
      prev_hold = r_out_valid && !w_out_ready;
      prev_data = r_out_data;
      if (r_done) busy_m = 0;
      else if (!busy_m && w_start) busy_m = 1;
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, r_busy, 0);
    chk({tag, "_done"}, r_done, 0);
    chk({tag, "_out_valid"}, r_out_valid, 0);
    chk({tag, "_out_last"}, r_out_last, 0);
    chk({tag, "_in_ready"}, r_in_ready, 0);
    chk({tag, "_out_data"}, r_out_data, 0);
    chk({tag, "_mem_ready"}, r_mem_ready, 0);
    chk({tag, "_mem_rw"}, r_mem_rw, 0);
    chk({tag, "_mem_addr"}, r_mem_address, 0);
    chk({tag, "_mem_din"}, r_mem_data_in, 0);
  endtask

  // vprob: 100 = valid always high, -1 = toggle, else percent chance
  task automatic run(input int len, input bit directed, input int vprob, input int rprob,
                     input bit hold_first, input int abort_at, output int waited,
                     output int hold_cnt);
    logic [7:0] data_arr[80];
    int eff, fidx;
    bit seen;
    eff = (len > 64) ? 64 : len;
    exp_q.delete();
    for (int i = 0; i < 80; i++) begin
      data_arr[i] = directed ? 8'(8'h11 * (i + 1)) : 8'($urandom_range(255));
      if (i < eff) exp_q.push_back(data_arr[i]);
    end
    store_idx = 0; out_idx = 0; n_done = 0; last_cnt = 0; mem_lo_cnt = 0;
    last_hs_cyc = -1;
    waited = 0; seen = 0; fidx = 0; hold_cnt = 0;
    @(posedge w_clk); #1;
    w_len = 7'(len); w_start = 1'b1;
    @(posedge w_clk); #1;
    w_start = 1'b0;
    while (waited < 3000) begin
      if (vprob == 100) w_in_valid = 1'b1;
      else if (vprob < 0) w_in_valid = ~w_in_valid;
      else w_in_valid = ($urandom_range(99) < vprob);
      w_in_data = data_arr[fidx];
      if (hold_first && r_out_valid && out_idx == 0 && hold_cnt < 5) begin
        w_out_ready = 1'b0;
        hold_cnt++;
      end else if (rprob == 100) w_out_ready = 1'b1;
      else w_out_ready = ($urandom_range(99) < rprob);
      @(negedge w_clk);
      if (w_in_valid && r_in_ready) fidx++;
      if (r_done) begin
        seen = 1;
        break;
      end
      @(posedge w_clk); #1;
      waited++;
      if (abort_at >= 0 && out_idx == abort_at && r_busy) begin
        w_rst_n = 1'b0;
        #1;
        reset_checks("mid_drain_reset");
        break;
      end
    end
    w_in_valid = 1'b0;
    if (abort_at < 0) begin
      chk("done_seen", seen, 1);
      chk("mem_ready_low_cycles", mem_lo_cnt, CLR_CYC);
      @(negedge w_clk);
      chk("done_single_pulse", r_done, 0);
    end else begin
      @(posedge w_clk); #1;
      w_rst_n = 1'b1;
    end
  endtask

  initial begin
    int waited, hold_cnt, nz;
    #2 w_rst_n = 1'b0;
    #1 reset_checks("reset");
    repeat (3) @(posedge w_clk);
    #1 w_rst_n = 1'b1;

    // four directed words, ready held high
    tput_chk = 1;
    run(4, 1, 100, 100, 0, -1, waited, hold_cnt);
    tput_chk = 0;
    chk("t1_stores", store_idx, 4);
    chk("t1_outs", out_idx, 4);
    chk("t1_done_count", n_done, 1);
    chk("t1_first_out", first_out, 8'h11);
    chk("t1_last_out", last_out, 8'h44);
    chk("t1_last_count", last_cnt, 1);

    // toggling valid
    run(3, 1, -1, 100, 0, -1, waited, hold_cnt);
    chk("t2_stores", store_idx, 3);
    chk("t2_last_out", last_out, 8'h33);

    // backpressure on the first output word
    run(2, 0, 100, 100, 1, -1, waited, hold_cnt);
    chk("t3_hold_cycles", hold_cnt, 5);
    chk("t3_outs", out_idx, 2);

    // zero length
    run(0, 0, 100, 100, 0, -1, waited, hold_cnt);
    chk("t4_len0_latency_ok", waited <= 2, 1);
    chk("t4_stores", store_idx, 0);
    chk("t4_outs", out_idx, 0);
    chk("t4_done_count", n_done, 1);

    // oversize length saturates to 64 rows
    run(100, 0, 70, 70, 0, -1, waited, hold_cnt);
    chk("t5_stores", store_idx, 64);
    chk("t5_outs", out_idx, 64);

    // reset while draining row 2 of 5, then a normal run
    run(5, 0, 100, 100, 0, 2, waited, hold_cnt);
    run(5, 0, 100, 100, 0, -1, waited, hold_cnt);
    chk("t6_outs_after_reset", out_idx, 5);

    // random lengths and handshake patterns
    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(1, 70)), 0, 60, 60, 0, -1, waited, hold_cnt);
    end

`ifdef PE_SEQ_DRAIN_CLEAR_EN
    run(1, 0, 100, 100, 0, -1, waited, hold_cnt);
    chk("clr_before_done", done_cyc - lo_cyc, 1);
    nz = 0;
    for (int i = 0; i < 64; i++) if (mem[i] != 8'h00) nz++;
    chk("clr_mem_zero", nz, 0);
`else
    nz = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
